icache_direct_mapped: RTL and testbench

//  Direct-mapped, one-word-per-line instruction cache between the instruction fetch unit and the memory controller.

---
 rtl/icache_direct_mapped_pkg.sv | 11 +
 rtl/icache_direct_mapped_array.sv | 34 +++
 rtl/icache_direct_mapped.sv | 105 ++++++++++
 tb/tb_icache_direct_mapped.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_direct_mapped_pkg.sv
// Shared defaults and FSM encoding for the direct-mapped instruction cache.
package icache_direct_mapped_pkg;
  localparam int INDEX_BITS_DEF = 8;
  localparam int ADDR_BITS_DEF  = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    DROP = 2'd2
  } state_e;
endpackage

// File: rtl/icache_direct_mapped_array.sv
// Line storage: a valid bit per line with async clear, and tag+data with one read and one write port.
module icache_array #(
  parameter int IDX_W = 8,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);
  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]    valid;
  logic [TAG_W+31:0]   mem [LINES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid <= '0;
    else if (we) valid[wr_idx] <= 1'b1;
  end

  // Tag/data need no reset: the valid bit gates every use.
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= {wr_tag, wr_data};
  end

  assign rd_valid          = valid[rd_idx];
  assign {rd_tag, rd_data} = mem[rd_idx];
endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped one-word-per-line I-cache: lookup FSM and fetch handshake around icache_array.
module icache_direct_mapped
  import icache_direct_mapped_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int ADDR_BITS  = ADDR_BITS_DEF
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        roll_back,
  input  logic        if_req,
  input  logic [31:0] if_pc,
  output logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic        fetch_start,
  output logic [31:0] fetch_pc,
  input  logic        finish_fetch,
  input  logic [31:0] fetch_instr_in
);
  localparam int TAG_W = ADDR_BITS - 2 - INDEX_BITS;

  state_e            state, state_nxt;
  logic              rd_valid, hit, fill_we;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_data;
  logic              rsp_vld, fs_nxt;
  logic [31:0]       rsp_data, fpc_nxt;
  logic              unused_pc_lsb;

  assign unused_pc_lsb = ^if_pc[1:0];

  // fetch_pc doubles as the latched miss address for the fill.
  icache_array #(.IDX_W(INDEX_BITS), .TAG_W(TAG_W)) u_array (
    .clk      (clk_in),
    .rst_n    (rst_in),
    .rd_idx   (if_pc[INDEX_BITS+1:2]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (fill_we & rdy_in),
    .wr_idx   (fetch_pc[INDEX_BITS+1:2]),
    .wr_tag   (fetch_pc[ADDR_BITS-1:2+INDEX_BITS]),
    .wr_data  (fetch_instr_in)
  );

  assign hit      = rd_valid && (rd_tag == if_pc[ADDR_BITS-1:2+INDEX_BITS]);
  assign if_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    fill_we   = 1'b0;
    rsp_vld   = 1'b0;
    rsp_data  = if_instr;
    fs_nxt    = fetch_start;
    fpc_nxt   = fetch_pc;
    case (state)
      IDLE: if (if_req && !roll_back) begin
        if (hit) begin
          rsp_vld  = 1'b1;
          rsp_data = rd_data;
        end else begin
          state_nxt = MISS;
          fs_nxt    = 1'b1;
          fpc_nxt   = {if_pc[31:2], 2'b00};
        end
      end
      MISS: if (finish_fetch) begin
        fill_we   = 1'b1;
        fs_nxt    = 1'b0;
        state_nxt = IDLE;
        if (!roll_back) begin
          rsp_vld  = 1'b1;
          rsp_data = fetch_instr_in;
        end
      end else if (roll_back) begin
        state_nxt = DROP;
      end
      // Flushed miss: the fetch still completes and the fill is still good.
      DROP: if (finish_fetch) begin
        fill_we   = 1'b1;
        fs_nxt    = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      fetch_start <= 1'b0;
      fetch_pc    <= '0;
    end else if (rdy_in) begin
      state       <= state_nxt;
      if_valid    <= rsp_vld;
      if_instr    <= rsp_data;
      fetch_start <= fs_nxt;
      fetch_pc    <= fpc_nxt;
    end
  end
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped: expected words queued at request, compared as pulses appear.
module tb_icache_direct_mapped;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, roll_back, if_req, finish_fetch;
  logic [31:0] if_pc, fetch_instr_in;
  logic        if_ready, if_valid, fetch_start;
  logic [31:0] if_instr, fetch_pc;

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic        upd = 1'b0;
  logic        fs_seen = 1'b0;

  bit          m_valid [256];
  logic [7:0]  m_tag   [256];
  logic [31:0] m_data  [256];

  icache_direct_mapped dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .roll_back(roll_back),
    .if_req(if_req), .if_pc(if_pc), .if_ready(if_ready), .if_valid(if_valid),
    .if_instr(if_instr), .fetch_start(fetch_start), .fetch_pc(fetch_pc),
    .finish_fetch(finish_fetch), .fetch_instr_in(fetch_instr_in)
  );

  always #5 clk_in = ~clk_in;

  // Capture each fresh if_valid cycle once (a stalled cycle repeats the previous value).
  always @(posedge clk_in) upd <= rdy_in & rst_in;
  always @(negedge clk_in) begin
    if (upd && if_valid) obs_q.push_back(if_instr);
    if (fetch_start) fs_seen <= 1'b1;
  end

  task automatic step();
    @(posedge clk_in); #1;
  endtask

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[9:2]] && (m_tag[pc[9:2]] == pc[17:10]);
  endfunction

  task automatic model_fill(input logic [31:0] pc, input logic [31:0] d);
    m_valid[pc[9:2]] = 1'b1;
    m_tag[pc[9:2]]   = pc[17:10];
    m_data[pc[9:2]]  = d;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; if_req = 1'b0;
    finish_fetch = 1'b0; if_pc = '0; fetch_instr_in = '0;
    model_reset();
    repeat (2) step();
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL reset_if_ready got=%b want=1", if_ready); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_if_valid got=%b want=0", if_valid); end
    checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL reset_fetch_start got=%b want=0", fetch_start); end
    checks++; if (fetch_pc !== 32'h0) begin failures++; $display("FAIL reset_fetch_pc got=%h want=0", fetch_pc); end
    checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_if_instr got=%h want=0", if_instr); end
    #3 rst_in = 1'b1;
    step();
  endtask

  task automatic test_cold_miss();
    logic [31:0] o, e;
    exp_q.push_back(32'h0000_0013);
    if_req = 1'b1; if_pc = 32'h0000_0004; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL cold_fetch_start got=%b want=1", fetch_start); end
    checks++; if (fetch_pc !== 32'h4) begin failures++; $display("FAIL cold_fetch_pc got=%h want=00000004", fetch_pc); end
    checks++; if (if_ready !== 1'b0) begin failures++; $display("FAIL cold_if_ready_busy got=%b want=0", if_ready); end
    repeat (3) step();
    finish_fetch = 1'b1; fetch_instr_in = 32'h0000_0013; step(); finish_fetch = 1'b0;
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL cold_if_valid got=%b want=1", if_valid); end
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL cold_if_ready_after got=%b want=1", if_ready); end
    checks++; if (fetch_start !== 1'b0) begin failures++; $display("FAIL cold_fetch_drop got=%b want=0", fetch_start); end
    model_fill(32'h4, 32'h0000_0013);
    @(negedge clk_in); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL cold_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL cold_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_hit_streak();
    logic [31:0] o, e;
    if_req = 1'b1; if_pc = 32'h0; step(); if_req = 1'b0;
    checks++; if (fetch_pc !== 32'h0 || fetch_start !== 1'b1) begin failures++; $display("FAIL streak_fill_miss got=%b/%h want=1/00000000", fetch_start, fetch_pc); end
    step();
    finish_fetch = 1'b1; fetch_instr_in = 32'h0000_0093; step(); finish_fetch = 1'b0;
    exp_q.push_back(32'h0000_0093);
    model_fill(32'h0, 32'h0000_0093);
    @(negedge clk_in); #1;
    fs_seen = 1'b0;
    if (model_hit(32'h0)) exp_q.push_back(m_data[0]);
    if (model_hit(32'h4)) exp_q.push_back(m_data[1]);
    if_req = 1'b1; if_pc = 32'h0; step();
    checks++; if (if_valid !== model_hit(32'h0)) begin failures++; $display("FAIL streak_hit0 got=%b want=1", if_valid); end
    if_pc = 32'h4; step(); if_req = 1'b0;
    checks++; if (if_valid !== model_hit(32'h4)) begin failures++; $display("FAIL streak_hit1 got=%b want=1", if_valid); end
    step();
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL streak_pulse_end got=%b want=0", if_valid); end
    @(negedge clk_in); #1;
    checks++; if (fs_seen !== 1'b0) begin failures++; $display("FAIL streak_no_fetch got=%b want=0", fs_seen); end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL streak_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL streak_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_alias();
    logic [31:0] o, e;
    if_req = 1'b1; if_pc = 32'h0404; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL alias_miss got=%b want=1", fetch_start); end
    checks++; if (fetch_pc !== 32'h0404) begin failures++; $display("FAIL alias_fetch_pc got=%h want=00000404", fetch_pc); end
    step();
    finish_fetch = 1'b1; fetch_instr_in = 32'hA1A1_0001; step(); finish_fetch = 1'b0;
    exp_q.push_back(32'hA1A1_0001);
    model_fill(32'h0404, 32'hA1A1_0001);
    checks++; if (model_hit(32'h4)) begin failures++; $display("FAIL alias_model_evict got=1 want=0"); end
    if_req = 1'b1; if_pc = 32'h0004; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL alias_remiss got=%b want=1", fetch_start); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL alias_no_hit got=%b want=0", if_valid); end
    finish_fetch = 1'b1; fetch_instr_in = 32'h0000_0013; step(); finish_fetch = 1'b0;
    exp_q.push_back(32'h0000_0013);
    model_fill(32'h4, 32'h0000_0013);
    @(negedge clk_in); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL alias_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL alias_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_rollback_miss();
    logic [31:0] o, e;
    if_req = 1'b1; if_pc = 32'h0100; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL rb_miss got=%b want=1", fetch_start); end
    roll_back = 1'b1; step(); roll_back = 1'b0;
    checks++; if (if_ready !== 1'b0 || fetch_start !== 1'b1) begin failures++; $display("FAIL rb_drop_state got=%b/%b want=0/1", if_ready, fetch_start); end
    step();
    finish_fetch = 1'b1; fetch_instr_in = 32'hDEAD_BEEF; step(); finish_fetch = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rb_no_valid got=%b want=0", if_valid); end
    checks++; if (if_ready !== 1'b1 || fetch_start !== 1'b0) begin failures++; $display("FAIL rb_idle got=%b/%b want=1/0", if_ready, fetch_start); end
    model_fill(32'h0100, 32'hDEAD_BEEF);
    if (model_hit(32'h0100)) exp_q.push_back(m_data[8'h40]);
    if_req = 1'b1; if_pc = 32'h0100; step(); if_req = 1'b0;
    checks++; if (if_valid !== 1'b1 || fetch_start !== 1'b0) begin failures++; $display("FAIL rb_refetch_hit got=%b/%b want=1/0", if_valid, fetch_start); end
    @(negedge clk_in); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rb_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL rb_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_same_cycle();
    logic [31:0] o, e;
    if_req = 1'b1; if_pc = 32'h0200; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL same_miss got=%b want=1", fetch_start); end
    step();
    finish_fetch = 1'b1; roll_back = 1'b1; fetch_instr_in = 32'hC0FF_EE00; step();
    finish_fetch = 1'b0; roll_back = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL same_no_valid got=%b want=0", if_valid); end
    checks++; if (if_ready !== 1'b1 || fetch_start !== 1'b0) begin failures++; $display("FAIL same_idle got=%b/%b want=1/0", if_ready, fetch_start); end
    model_fill(32'h0200, 32'hC0FF_EE00);
    // A flushed request in IDLE must produce nothing even though it would hit.
    if_req = 1'b1; roll_back = 1'b1; step(); roll_back = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL idle_rb_suppress got=%b want=0", if_valid); end
    if (model_hit(32'h0200)) exp_q.push_back(m_data[8'h80]);
    step(); if_req = 1'b0;
    checks++; if (if_valid !== 1'b1 || fetch_start !== 1'b0) begin failures++; $display("FAIL same_filled_hit got=%b/%b want=1/0", if_valid, fetch_start); end
    @(negedge clk_in); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL same_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL same_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_stall_reset();
    logic [31:0] o, e;
    if_req = 1'b1; if_pc = 32'h0300; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL stall_miss got=%b want=1", fetch_start); end
    rdy_in = 1'b0; finish_fetch = 1'b1; fetch_instr_in = 32'h0BAD_F00D;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fetch_start !== 1'b1 || if_valid !== 1'b0 || if_ready !== 1'b0 || fetch_pc !== 32'h0300) begin
        failures++;
        $display("FAIL stall_frozen cyc=%0d got=%b/%b/%b/%h want=1/0/0/00000300", i, fetch_start, if_valid, if_ready, fetch_pc);
      end
    end
    rdy_in = 1'b1; step(); finish_fetch = 1'b0;
    exp_q.push_back(32'h0BAD_F00D);
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h0BAD_F00D) begin failures++; $display("FAIL stall_resume got=%b/%h want=1/0badf00d", if_valid, if_instr); end
    model_fill(32'h0300, 32'h0BAD_F00D);
    @(negedge clk_in); #1;
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_sb_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL stall_sb_data got=%h want=%h", o, e); end
    end
    obs_q.delete(); exp_q.delete();
    if_req = 1'b1; if_pc = 32'h0400; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1) begin failures++; $display("FAIL rst_pre_miss got=%b want=1", fetch_start); end
    #2 rst_in = 1'b0;
    #1;
    checks++; if (if_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b want=1", if_ready); end
    checks++; if (fetch_start !== 1'b0 || fetch_pc !== 32'h0) begin failures++; $display("FAIL rst_async_fetch got=%b/%h want=0/00000000", fetch_start, fetch_pc); end
    model_reset();
    #4 rst_in = 1'b1;
    step();
    if_req = 1'b1; if_pc = 32'h0300; step(); if_req = 1'b0;
    checks++; if (fetch_start !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL rst_cleared_miss got=%b/%b want=1/0", fetch_start, if_valid); end
    finish_fetch = 1'b1; fetch_instr_in = 32'h0BAD_F00D; step(); finish_fetch = 1'b0;
    checks++; if (if_valid !== 1'b1 || if_instr !== 32'h0BAD_F00D) begin failures++; $display("FAIL rst_refill got=%b/%h want=1/0badf00d", if_valid, if_instr); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit_streak();
    test_alias();
    test_rollback_miss();
    test_same_cycle();
    test_stall_reset();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
